period_decoder: RTL and testbench

PERIOD_DECODER -- requirements
Module: period_decoder

---
 rtl/period_decoder_pkg.sv | 15 +
 rtl/period_decoder_edge_sync.sv | 52 +++++
 rtl/period_decoder.sv | 145 ++++++++++++++
 tb/tb_period_decoder.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/period_decoder_pkg.sv
// Purpose: shared types and constants for the period decoder.
// Holds the decoder state encoding and the default period-counter width.
// No logic; imported by period_decoder.
package period_decoder_pkg;

  localparam int unsigned CNT_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    CONFIRM = 2'd2,
    LOCKED  = 2'd3
  } state_e;

endpackage

// File: rtl/period_decoder_edge_sync.sv
// Purpose: 2-flop synchronizer plus registered rising-edge detector for din.
// Latency: rise pulses for one cycle, 3 clk edges after d is first sampled high.
// Backpressure: none; free-running sampler.
// Ports: clk, reset (async active-low), clear (sync), d (async input), rise (1-cycle pulse).
module edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic d,
  output logic rise
);

  logic sync1_q, sync2_q, prev_q;
  logic live1_q, live2_q;
  logic armed_q;
  logic rise_q;

  // live1_q/live2_q track that sync1_q/sync2_q hold genuine samples of d
  // rather than reset/clear values. armed_q only sets once a genuine low
  // has reached sync2_q, so d already high when reset/clear releases can
  // never be mistaken for a rising edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      live1_q <= 1'b0;
      live2_q <= 1'b0;
      armed_q <= 1'b0;
      rise_q  <= 1'b0;
    end else if (clear) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      live1_q <= 1'b0;
      live2_q <= 1'b0;
      armed_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= d;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      live1_q <= 1'b1;
      live2_q <= live1_q;
      armed_q <= armed_q | (live2_q & ~sync2_q);
      rise_q  <= sync2_q & ~prev_q & armed_q;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/period_decoder.sv
// Purpose: measures the period of din in clk cycles and locks after two equal periods.
// Latency: outputs registered, updated 1 cycle after the internal edge pulse (4 edges after din sampled high).
// Backpressure: none; outputs are level/pulse status only.
// Ports: clk, reset (async active-low), clear (sync), din (async pulse train),
//        period [CNT_W] locked period, valid (locked), err (1-cycle mismatch/overflow pulse).
module period_decoder
  import period_decoder_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             din,
  output logic [CNT_W-1:0] period,
  output logic             valid,
  output logic             err
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_MAX - CNT_ONE;

  logic             e;
  logic             ovf;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] ref_q, ref_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;

  edge_sync u_edge_sync (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .d     (din),
    .rise  (e)
  );

  // Counter saturates instead of wrapping so IDLE can sit indefinitely.
  always_comb begin
    cnt_d = cnt_q;
    if (e) begin
      cnt_d = CNT_ONE;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Overflow fires on the step where cnt would reach its maximum without an
  // edge, so a period of CNT_MAX is already out of range and err coincides
  // with cnt showing CNT_MAX. An edge in the same cycle takes priority.
  assign ovf = (state_q != IDLE) && !e && (cnt_q == CNT_LAST);

  // State register and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ref_q    <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else if (clear) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ref_q    <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ref_q    <= ref_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (e) state_d = MEASURE;
      end
      MEASURE: begin
        if (e)        state_d = CONFIRM;
        else if (ovf) state_d = IDLE;
      end
      CONFIRM: begin
        if (e && (cnt_q == ref_q)) state_d = LOCKED;
        else if (ovf)              state_d = IDLE;
      end
      LOCKED: begin
        if (e && (cnt_q != period_q)) state_d = CONFIRM;
        else if (ovf)                 state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values. period is never cleared by a mismatch or
  // overflow so the last locked value stays readable.
  always_comb begin
    ref_d    = ref_q;
    period_d = period_q;
    valid_d  = valid_q;
    err_d    = 1'b0;
    case (state_q)
      MEASURE: begin
        if (e) ref_d = cnt_q;
      end
      CONFIRM: begin
        if (e) begin
          if (cnt_q == ref_q) begin
            period_d = cnt_q;
            valid_d  = 1'b1;
          end else begin
            ref_d = cnt_q;
          end
        end
      end
      LOCKED: begin
        if (e && (cnt_q != period_q)) begin
          ref_d   = cnt_q;
          valid_d = 1'b0;
          err_d   = 1'b1;
        end
      end
      default: ;
    endcase
    if (ovf) begin
      valid_d = 1'b0;
      err_d   = 1'b1;
    end
  end

  assign period = period_q;
  assign valid  = valid_q;
  assign err    = err_q;

endmodule

// File: tb/tb_period_decoder.sv
// Bench for period_decoder: CNT_W=8 and CNT_W=4 instances share one din stream.
// Reference model works on rising-edge sample indices and interval lists.
module tb_period_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clear = 1'b0;
  logic       din = 1'b0;
  logic [7:0] period8;
  logic       valid8, err8;
  logic [3:0] period4;
  logic       valid4, err4;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  period_decoder #(.CNT_W(8)) dut8 (
    .clk(clk), .reset(reset), .clear(clear), .din(din),
    .period(period8), .valid(valid8), .err(err8)
  );

  period_decoder #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .clear(clear), .din(din),
    .period(period4), .valid(valid4), .err(err4)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A din rising edge is a high sample preceded by a genuine low sample.
  // Intervals between successive edges form a run; the decoder is locked
  // whenever the last two intervals of the run are equal. A gap of
  // (2^CNT_W - 2) samples without an edge ends the run with err. Results of
  // sample n are visible on the outputs after clock edge n+3.
  typedef struct {
    bit v;
    int p;
    bit er;
  } obs_t;

  int   max_gap [2] = '{254, 14};
  bit   prev_real, prev_d;
  int   n = 0;
  bit   run [2];
  int   last [2];
  bit   have_iv [2];
  int   prev_iv [2];
  bit   m_valid [2];
  int   m_period [2];
  bit   m_err [2];
  obs_t pipe [2][3];
  obs_t cur [2];

  function automatic void model_reset();
    prev_real = 1'b0;
    prev_d    = 1'b0;
    for (int k = 0; k < 2; k++) begin
      run[k]      = 1'b0;
      last[k]     = 0;
      have_iv[k]  = 1'b0;
      prev_iv[k]  = 0;
      m_valid[k]  = 1'b0;
      m_period[k] = 0;
      m_err[k]    = 1'b0;
      cur[k]      = '{v: 1'b0, p: 0, er: 1'b0};
      for (int j = 0; j < 3; j++) pipe[k][j] = '{v: 1'b0, p: 0, er: 1'b0};
    end
  endfunction

  function automatic void model_step(bit d);
    bit rise;
    int iv;
    n++;
    rise      = d && prev_real && !prev_d;
    prev_real = 1'b1;
    prev_d    = d;
    for (int k = 0; k < 2; k++) begin
      cur[k]     = pipe[k][0];
      pipe[k][0] = pipe[k][1];
      pipe[k][1] = pipe[k][2];
      m_err[k]   = 1'b0;
      if (rise) begin
        if (!run[k]) begin
          run[k]     = 1'b1;
          have_iv[k] = 1'b0;
        end else begin
          iv = n - last[k];
          if (have_iv[k] && iv == prev_iv[k]) begin
            m_valid[k]  = 1'b1;
            m_period[k] = iv;
          end else begin
            m_err[k]   = m_valid[k];
            m_valid[k] = 1'b0;
          end
          prev_iv[k] = iv;
          have_iv[k] = 1'b1;
        end
        last[k] = n;
      end else if (run[k] && (n - last[k]) == max_gap[k]) begin
        run[k]     = 1'b0;
        m_valid[k] = 1'b0;
        m_err[k]   = 1'b1;
      end
      pipe[k][2] = '{v: m_valid[k], p: m_period[k], er: m_err[k]};
    end
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset)     model_reset();
    else if (clear) model_reset();
    else            model_step(din);
  end

  always @(negedge clk) begin
    chk("valid8",  valid8,  cur[0].v);
    chk("period8", period8, cur[0].p);
    chk("err8",    err8,    cur[0].er);
    chk("valid4",  valid4,  cur[1].v);
    chk("period4", period4, cur[1].p);
    chk("err4",    err4,    cur[1].er);
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int hi, input int lo);
    din = 1'b1;
    repeat (hi) step();
    din = 1'b0;
    repeat (lo) step();
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin
    int h, l;
    model_reset();
    repeat (3) step();
    reset = 1'b1;
    repeat (6) step();
    chk("rst_valid8", valid8, 0);
    chk("rst_period8", period8, 0);

    // period 6, 3 high / 3 low
    repeat (6) pulse(3, 3);
    chk("p6_period8", period8, 6);
    chk("p6_valid8", valid8, 1);
    chk("p6_period4", period4, 6);

    // switch to period 8
    repeat (5) pulse(4, 4);
    chk("p8_period8", period8, 8);
    chk("p8_valid8", valid8, 1);

    // back to 6, then clear, then relock
    repeat (5) pulse(3, 3);
    pulse_clear();
    chk("clr_period8", period8, 0);
    chk("clr_valid8", valid8, 0);
    chk("clr_err8", err8, 0);
    repeat (6) pulse(3, 3);
    chk("relock_period8", period8, 6);
    chk("relock_valid8", valid8, 1);

    // alternating 4,5 never locks
    for (int i = 0; i < 6; i++) begin
      pulse(2, 2);
      pulse(2, 3);
    end
    chk("alt_valid8", valid8, 0);
    chk("alt_valid4", valid4, 0);

    // lock at 5 then hold din low: 4-bit overflows first, 8-bit later
    repeat (5) pulse(2, 3);
    repeat (30) step();
    chk("ovf4_valid4", valid4, 0);
    chk("ovf4_period4", period4, 5);
    chk("ovf4_valid8", valid8, 1);
    repeat (300) step();
    chk("ovf8_valid8", valid8, 0);
    chk("ovf8_period8", period8, 5);

    // largest decodable 4-bit period (14), then 15 which overflows
    repeat (4) pulse(7, 7);
    chk("p14_period4", period4, 14);
    chk("p14_valid4", valid4, 1);
    repeat (3) pulse(8, 7);
    repeat (5) step();
    chk("p15_valid4", valid4, 0);
    chk("p15_period4", period4, 14);
    chk("p15_period8", period8, 15);
    chk("p15_valid8", valid8, 1);

    // random trains: runs of steady periods with occasional clears
    repeat (12) begin
      h = $urandom_range(1, 8);
      l = $urandom_range(1, 8);
      if ($urandom_range(0, 5) == 0) pulse_clear();
      repeat ($urandom_range(1, 4)) pulse(h, l);
    end
    repeat (20) pulse($urandom_range(1, 9), $urandom_range(1, 9));

    // lock at 6, move to CONFIRM via a period-8 edge, then async reset
    repeat (4) pulse(3, 3);
    pulse(4, 4);
    din = 1'b1;
    repeat (6) step();
    chk("pre_rst_period8", period8, 6);
    chk("pre_rst_valid8", valid8, 0);
    @(posedge clk);
    #4;
    reset = 1'b0;
    #1;
    chk("arst_period8", period8, 0);
    chk("arst_valid8", valid8, 0);
    chk("arst_err8", err8, 0);
    chk("arst_period4", period4, 0);
    repeat (2) step();
    reset = 1'b1;
    repeat (10) step();
    chk("post_rst_valid8", valid8, 0);
    din = 1'b0;
    repeat (3) step();
    repeat (4) pulse(3, 3);
    repeat (10) step();
    chk("post_rst_period8", period8, 6);
    chk("post_rst_valid8b", valid8, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
